regfile_wb_arbiter: RTL and testbench

- Shares the single register-file write port between two writeback requesters.
- Requester A is the in-order pipeline WB stage. Requester B is a multi-cycle unit (mul/div/load-miss).
- A has priority. B is protected from starvation by an aging counter.
- The block drives registered write-enable, address and data into the 32x64 register file, which writes on negedge clk.

---
 rtl/wb_arb_pkg.sv | 20 ++
 rtl/wb_age_counter.sv | 38 +++
 rtl/regfile_wb_arbiter.sv | 159 +++++++++++++++
 tb/tb_regfile_wb_arbiter.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_arb_pkg.sv
// Shared types and constants for the register-file writeback arbiter.
package wb_arb_pkg;

  localparam int REG_ADDR_W = 5;
  localparam logic [REG_ADDR_W-1:0] X0_ADDR = 5'd0;

  localparam int XLEN_DEF     = 64;
  localparam int MAX_WAIT_DEF = 4;

  typedef enum logic {
    PRIO_A  = 1'b0,
    FORCE_B = 1'b1
  } arb_state_e;

  // Writes to x0 are architecturally discarded.
  function automatic logic is_x0(input logic [REG_ADDR_W-1:0] rd);
    return rd == X0_ADDR;
  endfunction

endpackage

// File: rtl/wb_age_counter.sv
// Saturating aging counter: clear wins over increment, never wraps past MAX_WAIT.
// at_limit reports that the value being loaded this cycle equals MAX_WAIT.
module wb_age_counter #(
  parameter int CNT_W    = 4,
  parameter int MAX_WAIT = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic inc,
  output logic at_limit
);

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(MAX_WAIT);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != LIMIT)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  assign at_limit = (cnt_d == LIMIT);

  // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Arbitrates the single register-file write port between the pipeline WB stage (A)
// and a multi-cycle unit (B). Optional statistics counters: WB_ARB_STATS_EN.
module regfile_wb_arbiter
  import wb_arb_pkg::*;
#(
  parameter int XLEN     = XLEN_DEF,
  parameter int MAX_WAIT = MAX_WAIT_DEF,
  parameter int CNT_W    = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  a_valid,
  output logic                  a_ready,
  input  logic [REG_ADDR_W-1:0] a_rd,
  input  logic [XLEN-1:0]       a_data,
  input  logic                  b_valid,
  output logic                  b_ready,
  input  logic [REG_ADDR_W-1:0] b_rd,
  input  logic [XLEN-1:0]       b_data,
  output logic                  rf_we,
  output logic [REG_ADDR_W-1:0] rf_waddr,
  output logic [XLEN-1:0]       rf_wdata,
  output logic                  b_forced
`ifdef WB_ARB_STATS_EN
  ,
  output logic [31:0]           stat_a_cnt,
  output logic [31:0]           stat_b_cnt,
  output logic [31:0]           stat_stall_cnt
`endif
);

  arb_state_e state_q, state_d;

  logic a_grant, b_grant, same_rd;
  logic cnt_clr, cnt_inc, cnt_at_limit;
  logic a_xfer, b_xfer;

  logic                  rf_we_q, rf_we_d;
  logic [REG_ADDR_W-1:0] rf_waddr_q, rf_waddr_d;
  logic [XLEN-1:0]       rf_wdata_q, rf_wdata_d;

  wb_age_counter #(
    .CNT_W   (CNT_W),
    .MAX_WAIT(MAX_WAIT)
  ) u_age (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (cnt_clr),
    .inc     (cnt_inc),
    .at_limit(cnt_at_limit)
  );

  // B's result is older, so on a same-register collision it must land first.
  assign same_rd = a_valid && b_valid && (a_rd == b_rd) && !is_x0(a_rd);

  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    a_grant = 1'b0;
    b_grant = 1'b0;
    cnt_clr = 1'b0;
    cnt_inc = 1'b0;
    unique case (state_q)
      PRIO_A: begin
        if (a_valid && !same_rd) begin
          a_grant = 1'b1;
        end else if (b_valid) begin
          b_grant = 1'b1;
        end
        cnt_inc = b_valid && !b_grant;
        cnt_clr = !cnt_inc;
      end
      FORCE_B: begin
        b_grant = b_valid;
        cnt_clr = 1'b1;
      end
      default: ;
    endcase
  end

  // Kept apart from the grant block because at_limit depends on cnt_inc.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      PRIO_A:  if (cnt_inc && cnt_at_limit) state_d = FORCE_B;
      FORCE_B: state_d = PRIO_A;
      default: state_d = PRIO_A;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= PRIO_A;
    end else begin
      state_q <= state_d;
    end
  end

  // Readies are forced low during reset so nothing is accepted into a flop held in reset.
  assign a_ready  = a_grant && rst_n;
  assign b_ready  = b_grant && rst_n;
  assign a_xfer   = a_ready;
  assign b_xfer   = b_ready;
  assign b_forced = (state_q == FORCE_B);

  always_comb begin
    rf_we_d    = (a_xfer && !is_x0(a_rd)) || (b_xfer && !is_x0(b_rd));
    rf_waddr_d = rf_waddr_q;
    rf_wdata_d = rf_wdata_q;
    if (rf_we_d) begin
      rf_waddr_d = a_xfer ? a_rd   : b_rd;
      rf_wdata_d = a_xfer ? a_data : b_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rf_we_q    <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
    end else begin
      rf_we_q    <= rf_we_d;
      rf_waddr_q <= rf_waddr_d;
      rf_wdata_q <= rf_wdata_d;
    end
  end

  assign rf_we    = rf_we_q;
  assign rf_waddr = rf_waddr_q;
  assign rf_wdata = rf_wdata_q;

`ifdef WB_ARB_STATS_EN
  logic [31:0] stat_a_q, stat_a_d;
  logic [31:0] stat_b_q, stat_b_d;
  logic [31:0] stat_stall_q, stat_stall_d;

  always_comb begin
    stat_a_d     = stat_a_q + (a_xfer ? 32'd1 : 32'd0);
    stat_b_d     = stat_b_q + (b_xfer ? 32'd1 : 32'd0);
    stat_stall_d = stat_stall_q + ((a_valid && !a_ready) ? 32'd1 : 32'd0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_a_q     <= '0;
      stat_b_q     <= '0;
      stat_stall_q <= '0;
    end else begin
      stat_a_q     <= stat_a_d;
      stat_b_q     <= stat_b_d;
      stat_stall_q <= stat_stall_d;
    end
  end

  assign stat_a_cnt     = stat_a_q;
  assign stat_b_cnt     = stat_b_q;
  assign stat_stall_cnt = stat_stall_q;
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Scoreboard bench for regfile_wb_arbiter: a priority/aging reference model predicts
// grants per cycle and queues expected writes; a monitor checks the registered port.
module tb_regfile_wb_arbiter;

  localparam int XLEN     = 64;
  localparam int MAX_WAIT = 4;

  typedef struct {
    logic            we;
    logic [4:0]      addr;
    logic [XLEN-1:0] data;
  } exp_t;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            a_valid, b_valid;
  logic            a_ready, b_ready;
  logic [4:0]      a_rd, b_rd;
  logic [XLEN-1:0] a_data, b_data;
  logic            rf_we;
  logic [4:0]      rf_waddr;
  logic [XLEN-1:0] rf_wdata;
  logic            b_forced;
`ifdef WB_ARB_STATS_EN
  logic [31:0]     stat_a_cnt, stat_b_cnt, stat_stall_cnt;
`endif

  regfile_wb_arbiter #(
    .XLEN    (XLEN),
    .MAX_WAIT(MAX_WAIT),
    .CNT_W   (4)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .a_valid (a_valid),
    .a_ready (a_ready),
    .a_rd    (a_rd),
    .a_data  (a_data),
    .b_valid (b_valid),
    .b_ready (b_ready),
    .b_rd    (b_rd),
    .b_data  (b_data),
    .rf_we   (rf_we),
    .rf_waddr(rf_waddr),
    .rf_wdata(rf_wdata),
    .b_forced(b_forced)
`ifdef WB_ARB_STATS_EN
    ,
    .stat_a_cnt    (stat_a_cnt),
    .stat_b_cnt    (stat_b_cnt),
    .stat_stall_cnt(stat_stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  exp_t            exp_q[$];
  logic [XLEN-1:0] rf_mirror[32];

  // Reference model state: consecutive denials of a valid B, last written address/data.
  int              denied;
  logic [4:0]      last_addr;
  logic [XLEN-1:0] last_data;
  int              m_a_cnt, m_b_cnt, m_stall_cnt;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    denied      = 0;
    last_addr   = '0;
    last_data   = '0;
    m_a_cnt     = 0;
    m_b_cnt     = 0;
    m_stall_cnt = 0;
    exp_q.delete();
  endtask

  // One arbitration cycle: apply inputs, predict grants, check readies, queue expected write.
  task automatic drive_cycle(input logic av, input logic [4:0] ard, input logic [XLEN-1:0] adata,
                             input logic bv, input logic [4:0] brd, input logic [XLEN-1:0] bdata,
                             output logic ga, output logic gb);
    logic forced;
    exp_t e;
    @(negedge clk);
    a_valid = av; a_rd = ard; a_data = adata;
    b_valid = bv; b_rd = brd; b_data = bdata;
    #1;
    forced = (denied >= MAX_WAIT);
    ga = 1'b0;
    gb = 1'b0;
    if (forced)                                gb = bv;
    else if (av && bv && ard == brd && ard != 0) gb = 1'b1;
    else if (av)                               ga = 1'b1;
    else if (bv)                               gb = 1'b1;
    check("a_ready", 64'(a_ready), 64'(ga));
    check("b_ready", 64'(b_ready), 64'(gb));
    check("b_forced", 64'(b_forced), 64'(forced));
    if (bv && !gb) denied = (denied < MAX_WAIT) ? denied + 1 : MAX_WAIT;
    else           denied = 0;
    e.we = (ga && ard != 0) || (gb && brd != 0);
    if (e.we) begin
      last_addr = ga ? ard : brd;
      last_data = ga ? adata : bdata;
    end
    e.addr = last_addr;
    e.data = last_data;
    exp_q.push_back(e);
    m_a_cnt     += ga ? 1 : 0;
    m_b_cnt     += gb ? 1 : 0;
    m_stall_cnt += (av && !ga) ? 1 : 0;
  endtask

  task automatic idle_cycle();
    logic ga, gb;
    drive_cycle(1'b0, 5'd0, '0, 1'b0, 5'd0, '0, ga, gb);
  endtask

  // Monitor: one registered write-port result per cycle, compared in issue order.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (rst_n && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("rf_we", 64'(rf_we), 64'(e.we));
        check("rf_waddr", 64'(rf_waddr), 64'(e.addr));
        check("rf_wdata", rf_wdata, e.data);
        if (rf_we) rf_mirror[rf_waddr] = rf_wdata;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    logic ga, gb;
    logic a_pend, b_pend;
    logic [4:0] ard_r, brd_r;
    logic [XLEN-1:0] ad_r, bd_r;

    for (int i = 0; i < 32; i++) rf_mirror[i] = '0;
    model_reset();

    // Reset with both requesters asserting.
    rst_n = 1'b0;
    a_valid = 1'b1; a_rd = 5'd3; a_data = 64'h33;
    b_valid = 1'b1; b_rd = 5'd4; b_data = 64'h44;
    repeat (3) @(negedge clk);
    #1;
    check("rst_a_ready", 64'(a_ready), 64'd0);
    check("rst_b_ready", 64'(b_ready), 64'd0);
    check("rst_rf_we", 64'(rf_we), 64'd0);
    check("rst_rf_waddr", 64'(rf_waddr), 64'd0);
    check("rst_rf_wdata", rf_wdata, 64'd0);
    check("rst_b_forced", 64'(b_forced), 64'd0);
    a_valid = 1'b0;
    b_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    // Single grants.
    drive_cycle(1'b1, 5'd5, 64'h11, 1'b0, 5'd0, '0, ga, gb);
    drive_cycle(1'b0, 5'd0, '0, 1'b1, 5'd7, 64'hBEEF, ga, gb);
    idle_cycle();

    // Starvation: A busy every cycle, B waits MAX_WAIT then is forced through.
    for (int i = 0; i < MAX_WAIT + 2; i++) begin
      drive_cycle(1'b1, 5'd1, 64'(100 + i), !gb || i == 0, 5'd2, 64'hB0, ga, gb);
    end
    idle_cycle();

    // WAW ordering on a shared destination.
    drive_cycle(1'b1, 5'd9, 64'd1, 1'b1, 5'd9, 64'd2, ga, gb);
    drive_cycle(1'b1, 5'd9, 64'd1, 1'b0, 5'd0, '0, ga, gb);
    idle_cycle();
    check("waw_reg9_final", rf_mirror[9], 64'd1);

    // x0 write accepted but suppressed.
    drive_cycle(1'b1, 5'd0, 64'hFF, 1'b0, 5'd0, '0, ga, gb);
    idle_cycle();

    // Asynchronous reset while B is being forced.
    for (int i = 0; i <= MAX_WAIT; i++) begin
      drive_cycle(1'b1, 5'd3, 64'(200 + i), 1'b1, 5'd4, 64'hC4, ga, gb);
    end
    check("pre_reset_forced", 64'(b_forced), 64'd1);
    #1;
    rst_n = 1'b0;
    #1;
    check("mid_rst_rf_we", 64'(rf_we), 64'd0);
    check("mid_rst_rf_waddr", 64'(rf_waddr), 64'd0);
    check("mid_rst_rf_wdata", rf_wdata, 64'd0);
    check("mid_rst_b_forced", 64'(b_forced), 64'd0);
    check("mid_rst_b_ready", 64'(b_ready), 64'd0);
`ifdef WB_ARB_STATS_EN
    check("mid_rst_stat_a", 64'(stat_a_cnt), 64'd0);
    check("mid_rst_stat_b", 64'(stat_b_cnt), 64'd0);
    check("mid_rst_stat_stall", 64'(stat_stall_cnt), 64'd0);
`endif
    model_reset();
    a_valid = 1'b0;
    b_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    // Fresh PRIO_A with a cleared counter: A wins and B needs MAX_WAIT denials again.
    for (int i = 0; i <= MAX_WAIT; i++) begin
      drive_cycle(1'b1, 5'd3, 64'(300 + i), 1'b1, 5'd4, 64'hC4, ga, gb);
      if (gb) break;
    end
    idle_cycle();

    // Randomised traffic; requesters hold payload until their transfer.
    a_pend = 1'b0;
    b_pend = 1'b0;
    ard_r = '0; brd_r = '0; ad_r = '0; bd_r = '0;
    for (int n = 0; n < 500; n++) begin
      if (!a_pend && $urandom_range(0, 3) != 0) begin
        a_pend = 1'b1;
        ard_r  = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 3));
        ad_r   = {$urandom, $urandom};
      end
      if (!b_pend && $urandom_range(0, 2) == 0) begin
        b_pend = 1'b1;
        brd_r  = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 3));
        bd_r   = {$urandom, $urandom};
      end
      drive_cycle(a_pend, ard_r, ad_r, b_pend, brd_r, bd_r, ga, gb);
      if (ga) a_pend = 1'b0;
      if (gb) b_pend = 1'b0;
    end
    idle_cycle();
    @(posedge clk);
    #2;
    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
`ifdef WB_ARB_STATS_EN
    check("stat_a_cnt", 64'(stat_a_cnt), 64'(m_a_cnt));
    check("stat_b_cnt", 64'(stat_b_cnt), 64'(m_b_cnt));
    check("stat_stall_cnt", 64'(stat_stall_cnt), 64'(m_stall_cnt));
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
